// File: rtl/si_bullet_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | si_bullet_datapath: player-bullet position, step timer and hit detection   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module si_bullet_datapath #(
  parameter int STEP_TICKS = 2500000,
  parameter int TIMER_W    = 22
) (
  input  logic        SI_BULLET_DATAPATH_CLOCK_50,
  input  logic        SI_BULLET_DATAPATH_RESET_InLow,
  input  logic        SI_BULLET_DATAPATH_ENABLEC_IN,
  input  logic        SI_BULLET_DATAPATH_LOAD_InLow,
  input  logic        SI_BULLET_DATAPATH_CLEAR_InLow,
  input  logic        SI_BULLET_DATAPATH_CTLMUX_IN,
  input  logic [2:0]  SI_BULLET_DATAPATH_PLAYER_COL_IN,
  input  logic [63:0] SI_BULLET_DATAPATH_ALIEN_MASK_IN,
  output logic        SI_BULLET_DATAPATH_COUNT1_OutLow,
  output logic        SI_BULLET_DATAPATH_COUNT7_OutLow,
  output logic        SI_BULLET_DATAPATH_BULLET_OutLow,
  output logic [63:0] SI_BULLET_DATAPATH_MATRIX_OUT,
  output logic        SI_BULLET_DATAPATH_HIT_VALID_OUT,
  output logic [2:0]  SI_BULLET_DATAPATH_HIT_ROW_OUT,
  output logic [2:0]  SI_BULLET_DATAPATH_HIT_COL_OUT,
  output logic [7:0]  SI_BULLET_DATAPATH_SHOTS_OUT
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_TICKS - 1);

  logic               active_q, active_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         shots_q, shots_d;
  logic               count1_q, count1_d;
  logic               bullet_q, bullet_d;
  logic               hit_valid_q, hit_valid_d;
  logic [2:0]         hit_row_q, hit_row_d;
  logic [2:0]         hit_col_q, hit_col_d;

  logic       strobe;
  logic       spawn;
  logic       shift;
  logic [5:0] pos;
  logic       on_alien;

  assign strobe   = ~SI_BULLET_DATAPATH_LOAD_InLow;
  assign spawn    = strobe & ~SI_BULLET_DATAPATH_CTLMUX_IN & ~active_q;
  assign shift    = strobe &  SI_BULLET_DATAPATH_CTLMUX_IN &  active_q;
  assign pos      = {row_q, col_q};
  assign on_alien = active_q & SI_BULLET_DATAPATH_ALIEN_MASK_IN[pos];

  always_comb begin
    active_d    = active_q;
    row_d       = row_q;
    col_d       = col_q;
    timer_d     = timer_q;
    shots_d     = shots_q;
    count1_d    = 1'b1;
    bullet_d    = 1'b1;
    hit_valid_d = 1'b0;
    hit_row_d   = hit_row_q;
    hit_col_d   = hit_col_q;

    // A spawn restarts the step period so the first shift lands a full step later.
    if (!SI_BULLET_DATAPATH_CLEAR_InLow || spawn) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_d  = '0;
      count1_d = 1'b0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (spawn) begin
      active_d = 1'b1;
      row_d    = 3'd7;
      col_d    = SI_BULLET_DATAPATH_PLAYER_COL_IN;
      if (SI_BULLET_DATAPATH_ENABLEC_IN && shots_q != 8'hFF) begin
        shots_d = shots_q + 8'd1;
      end
    end else if (on_alien) begin
      active_d    = 1'b0;
      hit_valid_d = 1'b1;
      bullet_d    = 1'b0;
      hit_row_d   = row_q;
      hit_col_d   = col_q;
    end else if (shift) begin
      if (row_q == 3'd0) begin
        active_d = 1'b0;
      end else begin
        row_d = row_q - 3'd1;
      end
    end
  end

  always_ff @(posedge SI_BULLET_DATAPATH_CLOCK_50) begin
    if (!SI_BULLET_DATAPATH_RESET_InLow) begin
      active_q    <= 1'b0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      timer_q     <= '0;
      shots_q     <= 8'd0;
      count1_q    <= 1'b1;
      bullet_q    <= 1'b1;
      hit_valid_q <= 1'b0;
      hit_row_q   <= 3'd0;
      hit_col_q   <= 3'd0;
    end else begin
      active_q    <= active_d;
      row_q       <= row_d;
      col_q       <= col_d;
      timer_q     <= timer_d;
      shots_q     <= shots_d;
      count1_q    <= count1_d;
      bullet_q    <= bullet_d;
      hit_valid_q <= hit_valid_d;
      hit_row_q   <= hit_row_d;
      hit_col_q   <= hit_col_d;
    end
  end

  assign SI_BULLET_DATAPATH_COUNT1_OutLow  = count1_q;
  assign SI_BULLET_DATAPATH_COUNT7_OutLow  = active_q;
  assign SI_BULLET_DATAPATH_BULLET_OutLow  = bullet_q;
  assign SI_BULLET_DATAPATH_MATRIX_OUT     = active_q ? (64'd1 << pos) : 64'd0;
  assign SI_BULLET_DATAPATH_HIT_VALID_OUT  = hit_valid_q;
  assign SI_BULLET_DATAPATH_HIT_ROW_OUT    = hit_row_q;
  assign SI_BULLET_DATAPATH_HIT_COL_OUT    = hit_col_q;
  assign SI_BULLET_DATAPATH_SHOTS_OUT      = shots_q;

endmodule
`default_nettype wire
